// File: rtl/microcode_loader.sv
// Boot-time loader and write arbiter for the horizontal microcode store.
// Streams DEPTH words plus one checksum beat, then forwards kernel MMIO writes to the single store write port.
module microcode_loader #(
  parameter int WIDTH  = 19,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_valid_i,
  input  logic [WIDTH-1:0]  load_data_i,
  output logic              load_ready_o,
  input  logic              reload_i,
  input  logic              kwr_req_i,
  input  logic [ADDR_W-1:0] kwr_addr_i,
  input  logic [WIDTH-1:0]  kwr_data_i,
  output logic              kwr_ack_o,
  output logic              mc_we_o,
  output logic [ADDR_W-1:0] mc_waddr_o,
  output logic [WIDTH-1:0]  mc_wdata_o,
  output logic              core_run_o,
  output logic              done_o,
  output logic              error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_READY,
    S_ERROR
  } state_t;

  // The count is one bit wider than the address so it can reach DEPTH.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  state_t              r_state, w_state_nxt;
  logic [ADDR_W:0]     r_count, w_count_nxt;
  logic [WIDTH-1:0]    r_sum, w_sum_nxt;
  logic                w_accept;
  logic                w_load_wr;
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [WIDTH-1:0]    w_wr_data;

  assign load_ready_o = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign w_accept     = load_valid_i & load_ready_o;
  assign kwr_ack_o    = kwr_req_i & (r_state == S_READY) & ~reload_i;
  assign core_run_o   = (r_state == S_READY);
  assign done_o       = (r_state == S_READY);
  assign error_o      = (r_state == S_ERROR);

  // NOTE: every signal gets a default before any branch, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_sum_nxt   = r_sum;
    w_load_wr   = 1'b0;
    if (reload_i && (r_state != S_IDLE)) begin
      w_state_nxt = S_LOAD;
      w_count_nxt = '0;
      w_sum_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt = S_LOAD;
          w_count_nxt = '0;
          w_sum_nxt   = '0;
        end
        S_LOAD: begin
          if (w_accept) begin
            w_load_wr   = 1'b1;
            w_sum_nxt   = r_sum + load_data_i;
            w_count_nxt = r_count + 1'b1;
            if (r_count == LAST_IDX) w_state_nxt = S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_accept) w_state_nxt = (load_data_i == r_sum) ? S_READY : S_ERROR;
        end
        default: ;
      endcase
    end
  end

  // Load beats and kernel acks are exclusive by state, so one mux suffices.
  assign w_wr_en   = w_load_wr | kwr_ack_o;
  assign w_wr_addr = w_load_wr ? r_count[ADDR_W-1:0] : kwr_addr_i;
  assign w_wr_data = w_load_wr ? load_data_i : kwr_data_i;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_sum   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_sum   <= w_sum_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mc_we_o    <= 1'b0;
      mc_waddr_o <= '0;
      mc_wdata_o <= '0;
    end else begin
      mc_we_o <= w_wr_en;
      if (w_wr_en) begin
        mc_waddr_o <= w_wr_addr;
        mc_wdata_o <= w_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_microcode_loader.sv
// Self-checking bench for microcode_loader: scoreboarded store writes plus a kernel-port vector table.
module tb_microcode_loader;

  localparam int WIDTH  = 19;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_valid_i;
  logic [WIDTH-1:0]  load_data_i;
  logic              load_ready_o;
  logic              reload_i;
  logic              kwr_req_i;
  logic [ADDR_W-1:0] kwr_addr_i;
  logic [WIDTH-1:0]  kwr_data_i;
  logic              kwr_ack_o;
  logic              mc_we_o;
  logic [ADDR_W-1:0] mc_waddr_o;
  logic [WIDTH-1:0]  mc_wdata_o;
  logic              core_run_o;
  logic              done_o;
  logic              error_o;

  microcode_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_valid_i (load_valid_i),
    .load_data_i  (load_data_i),
    .load_ready_o (load_ready_o),
    .reload_i     (reload_i),
    .kwr_req_i    (kwr_req_i),
    .kwr_addr_i   (kwr_addr_i),
    .kwr_data_i   (kwr_data_i),
    .kwr_ack_o    (kwr_ack_o),
    .mc_we_o      (mc_we_o),
    .mc_waddr_o   (mc_waddr_o),
    .mc_wdata_o   (mc_wdata_o),
    .core_run_o   (core_run_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int e_cyc;
  } wr_t;

  typedef struct {
    logic              req;
    logic              reload;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
    logic              exp_ack;
  } kvec_t;

  wr_t   sb[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    edge_count = 0;
  kvec_t kv[5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) edge_count <= edge_count + 1;

  // Store-write monitor: every write must match the oldest expected entry in the cycle after its accept.
  always @(negedge clk) begin
    if (!rst && mc_we_o) begin
      if (sb.size() == 0) begin
        check("unexpected_write_addr", int'(mc_waddr_o), -1);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", int'(mc_waddr_o), e.addr);
        check("wr_data", int'(mc_wdata_o), e.data);
        check("wr_latency", edge_count, e.e_cyc);
      end
    end
  end

  // Called #1 after an edge; returns #1 after the edge that took the beat.
  task automatic send_beat(input logic [WIDTH-1:0] d, input bit is_data, input int addr);
    int waited = 0;
    load_valid_i = 1'b1;
    load_data_i  = d;
    while (!load_ready_o && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!load_ready_o) check("ready_timeout", 0, 1);
    @(posedge clk); #1;
    if (is_data) sb.push_back('{addr, int'(d), edge_count});
    load_valid_i = 1'b0;
  endtask

  task automatic pulse_reload();
    reload_i = 1'b1;
    @(posedge clk); #1;
    reload_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] sum;

    kv[0] = '{1'b1, 1'b0, 6'd5,  19'h7FFFF, 1'b1};
    kv[1] = '{1'b0, 1'b0, 6'd9,  19'h00123, 1'b0};
    kv[2] = '{1'b1, 1'b0, 6'd63, 19'h1ABCD, 1'b1};
    kv[3] = '{1'b1, 1'b0, 6'd0,  19'h00001, 1'b1};
    kv[4] = '{1'b1, 1'b1, 6'd7,  19'h00055, 1'b0};

    rst = 1'b1; load_valid_i = 1'b0; load_data_i = '0; reload_i = 1'b0;
    kwr_req_i = 1'b0; kwr_addr_i = '0; kwr_data_i = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", int'(load_ready_o), 0);
    check("rst_we", int'(mc_we_o), 0);
    check("rst_run", int'(core_run_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_error", int'(error_o), 0);
    @(negedge clk); rst = 1'b0;
    check("idle_ready", int'(load_ready_o), 0);
    @(posedge clk); #1;
    check("load_after_release", int'(load_ready_o), 1);

    // Test 1: back-to-back stream w[i]=i, correct checksum.
    for (int i = 0; i < DEPTH; i++) send_beat(WIDTH'(i), 1'b1, i);
    check("check_state_ready", int'(load_ready_o), 1);
    check("check_not_done", int'(done_o), 0);
    send_beat(19'd2016, 1'b0, 0);
    check("t1_done", int'(done_o), 1);
    check("t1_run", int'(core_run_o), 1);
    check("t1_ready_low", int'(load_ready_o), 0);
    check("t1_error", int'(error_o), 0);

    // Tests 3 and 4: kernel writes in READY, last vector collides with reload.
    for (int v = 0; v < 5; v++) begin
      kwr_req_i  = kv[v].req;
      reload_i   = kv[v].reload;
      kwr_addr_i = kv[v].addr;
      kwr_data_i = kv[v].data;
      #2;
      check($sformatf("kv%0d_ack", v), int'(kwr_ack_o), int'(kv[v].exp_ack));
      if (kv[v].exp_ack) sb.push_back('{int'(kv[v].addr), int'(kv[v].data), edge_count + 1});
      @(posedge clk); #1;
      kwr_req_i = 1'b0;
      reload_i  = 1'b0;
      check($sformatf("kv%0d_run", v), int'(core_run_o), kv[v].reload ? 0 : 1);
      check($sformatf("kv%0d_ready", v), int'(load_ready_o), kv[v].reload ? 1 : 0);
    end
    @(posedge clk); #1;
    check("t4_no_write", int'(mc_we_o), 0);

    // Test 2: same stream, bad checksum, kernel request held throughout.
    kwr_req_i = 1'b1; kwr_addr_i = 6'd3; kwr_data_i = 19'h00777;
    for (int i = 0; i < DEPTH; i++) send_beat(WIDTH'(i), 1'b1, i);
    send_beat(19'd2015, 1'b0, 0);
    check("t2_error", int'(error_o), 1);
    check("t2_run", int'(core_run_o), 0);
    check("t2_done", int'(done_o), 0);
    check("t2_ready_low", int'(load_ready_o), 0);
    for (int c = 0; c < 5; c++) begin
      check("t2_no_ack", int'(kwr_ack_o), 0);
      @(posedge clk); #1;
    end
    kwr_req_i = 1'b0;
    pulse_reload();
    check("t2_reload_error_clr", int'(error_o), 0);
    check("t2_reload_ready", int'(load_ready_o), 1);

    // Test 5: 30 words with random gaps, reload while a beat is offered, then a full load.
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_beat(WIDTH'(500 + i), 1'b1, i);
    end
    load_valid_i = 1'b1; load_data_i = 19'h0ABCD;
    pulse_reload();
    load_valid_i = 1'b0;
    sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
      send_beat(WIDTH'(100 + i), 1'b1, i);
      sum = sum + WIDTH'(100 + i);
    end
    send_beat(sum, 1'b0, 0);
    check("t5_done", int'(done_o), 1);
    check("t5_error", int'(error_o), 0);

    // Test 6: reset between edges with a write pending at count=17.
    pulse_reload();
    for (int i = 0; i < 17; i++) send_beat(WIDTH'(256 + i), 1'b1, i);
    rst = 1'b1;
    #1;
    sb.delete();
    check("t6_we", int'(mc_we_o), 0);
    check("t6_ready", int'(load_ready_o), 0);
    check("t6_run", int'(core_run_o), 0);
    check("t6_done", int'(done_o), 0);
    check("t6_error", int'(error_o), 0);
    check("t6_addr", int'(mc_waddr_o), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check("t6_idle_ready", int'(load_ready_o), 0);
    @(posedge clk); #1;
    check("t6_load_ready", int'(load_ready_o), 1);
    send_beat(19'h00055, 1'b1, 0);

    repeat (3) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
